// File: rtl/terracresta_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | terracresta_pkg                                                    |
// | Shared constants for the sound-CPU communication block.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package terracresta_pkg;

  localparam int unsigned c_irq_period_default = 200_000;
  localparam logic [7:0]  c_dac_reset          = 8'h80;

  // Slot of each strobe in the shared edge-detector vector
  localparam int c_edge_m68k_wr  = 0;
  localparam int c_edge_z80_rd   = 1;
  localparam int c_edge_z80_clr  = 2;
  localparam int c_edge_dac1     = 3;
  localparam int c_edge_dac2     = 4;
  localparam int c_edge_int_ack  = 5;
  localparam int c_num_edges     = 6;

endpackage
`default_nettype wire

// File: rtl/rise_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rise_pulse                                                         |
// | One-bit rising-edge detector with registered history.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rise_pulse (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk_sys) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_sig;
  end

  assign o_pulse = i_sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/sound_comm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sound_comm                                                         |
// | M68K->Z80 command latch, Z80 DAC registers and Z80 timer IRQ.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sound_comm
  import terracresta_pkg::*;
#(
  parameter int unsigned IRQ_PERIOD = c_irq_period_default
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       sound_latch_cs,
  input  logic       m68k_rw,
  input  logic       m68k_lds_n,
  input  logic [7:0] m68k_dout,
  input  logic       z80_latch_r_cs,
  input  logic       z80_latch_clr_cs,
  input  logic       z80_dac1_cs,
  input  logic       z80_dac2_cs,
  input  logic       z80_wr_n,
  input  logic       z80_rd_n,
  input  logic       M1_n,
  input  logic       IORQ_n,
  input  logic [7:0] z80_dout,
  output logic [7:0] latch_dout,
  output logic       latch_pending,
  output logic       z80_irq_n,
  output logic [7:0] dac1,
  output logic [7:0] dac2
);

  localparam int c_cnt_w = (IRQ_PERIOD > 2) ? $clog2(IRQ_PERIOD) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(IRQ_PERIOD - 1);

  logic [c_num_edges-1:0] w_level;
  logic [c_num_edges-1:0] w_edge;
  logic [7:0]             r_latch;
  logic                   r_pending;
  logic [7:0]             r_dac1;
  logic [7:0]             r_dac2;
  logic [c_cnt_w-1:0]     r_count;
  logic                   r_irq_req;
  logic                   w_tick;

  always_comb begin
    w_level                 = '0;
    w_level[c_edge_m68k_wr] = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
    w_level[c_edge_z80_rd]  = z80_latch_r_cs & ~z80_rd_n;
    w_level[c_edge_z80_clr] = z80_latch_clr_cs & ~z80_wr_n;
    w_level[c_edge_dac1]    = z80_dac1_cs & ~z80_wr_n;
    w_level[c_edge_dac2]    = z80_dac2_cs & ~z80_wr_n;
    w_level[c_edge_int_ack] = ~M1_n & ~IORQ_n;
  end

  // Each strobe acts only once per bus cycle, on its first active clock
  for (genvar i = 0; i < c_num_edges; i++) begin : g_edge
    rise_pulse u_rise (
      .clk_sys (clk_sys),
      .reset   (reset),
      .i_sig   (w_level[i]),
      .o_pulse (w_edge[i])
    );
  end

  // A new M68K command always wins over a coincident Z80 clear or read
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_latch   <= 8'h00;
      r_pending <= 1'b0;
    end else if (w_edge[c_edge_m68k_wr]) begin
      r_latch   <= m68k_dout;
      r_pending <= 1'b1;
    end else if (w_edge[c_edge_z80_clr]) begin
      r_latch   <= 8'h00;
      r_pending <= 1'b0;
    end else if (w_edge[c_edge_z80_rd]) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dac1 <= c_dac_reset;
      r_dac2 <= c_dac_reset;
    end else begin
      if (w_edge[c_edge_dac1]) r_dac1 <= z80_dout;
      if (w_edge[c_edge_dac2]) r_dac2 <= z80_dout;
    end
  end

  assign w_tick = (r_count == c_cnt_max);

  always_ff @(posedge clk_sys) begin
    if (reset)       r_count <= '0;
    else if (w_tick) r_count <= '0;
    else             r_count <= r_count + c_cnt_w'(1);
  end

  // Ticks while already pending are dropped; a tick beats a coincident ack
  always_ff @(posedge clk_sys) begin
    if (reset)                        r_irq_req <= 1'b0;
    else if (w_tick)                  r_irq_req <= 1'b1;
    else if (w_edge[c_edge_int_ack])  r_irq_req <= 1'b0;
  end

  assign latch_dout    = r_latch;
  assign latch_pending = r_pending;
  assign z80_irq_n     = ~r_irq_req;
  assign dac1          = r_dac1;
  assign dac2          = r_dac2;

endmodule
`default_nettype wire

// File: doc/sound_comm.md
SOUND_COMM -- requirements
Module: sound_comm

Interface
REQ-001 SHALL have parameter IRQ_PERIOD, default 'd200_000, meaning clk_sys cycles between Z80 timer IRQ requests (minimum 2).
REQ-002 SHALL have ports: clk_sys  in  1  system clock; every register updates on its rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: sound_latch_cs  in  1  M68K sound-latch select, already qualified by !AS.
REQ-005 SHALL have ports: m68k_rw  in  1  M68K read/write (0 = write).
REQ-006 SHALL have ports: m68k_lds_n  in  1  M68K lower data strobe, active low.
REQ-007 SHALL have ports: m68k_dout  in  8  M68K data bus bits 7:0.
REQ-008 SHALL have ports: z80_latch_r_cs, z80_latch_clr_cs, z80_dac1_cs, z80_dac2_cs  in  1 each  Z80 I/O selects.
REQ-009 SHALL have ports: z80_wr_n, z80_rd_n, M1_n, IORQ_n  in  1 each  Z80 bus strobes, active low.
REQ-010 SHALL have ports: z80_dout  in  8  Z80 data bus out.
REQ-011 SHALL have ports: latch_dout  out  8  latched command byte; latch_pending  out  1  unread-command flag; z80_irq_n  out  1  Z80 INT, active low; dac1, dac2  out  8 each  DAC sample registers.

Function
REQ-012 SHALL detect an M68K latch write as the first clk_sys cycle in which sound_latch_cs & !m68k_rw & !m68k_lds_n is true after a cycle in which it was false; exactly one write per bus cycle.
REQ-013 SHALL, on an M68K latch write, load m68k_dout into latch_dout and set latch_pending on the next clock edge (latency 1 cycle).
REQ-014 SHALL drive latch_dout combinationally from the latch register; a Z80 read (z80_latch_r_cs & !z80_rd_n) SHALL clear latch_pending on its rising edge only, and SHALL leave latch_dout unchanged.
REQ-015 SHALL, on the rising edge of z80_latch_clr_cs & !z80_wr_n, load latch_dout with 8'h00 and clear latch_pending.
REQ-016 SHALL give priority to the M68K write when it coincides with a Z80 clear or read: latch_dout = new data, latch_pending = 1.
REQ-017 SHALL load z80_dout into dac1 (or dac2) on the rising edge of z80_dac1_cs & !z80_wr_n (or z80_dac2_cs & !z80_wr_n), latency 1 cycle.
REQ-018 SHALL run a free-running counter from 0 to IRQ_PERIOD-1 that wraps to 0; reaching IRQ_PERIOD-1 SHALL set irq_req on the next edge.
REQ-019 SHALL drive z80_irq_n = !irq_req.
REQ-020 SHALL clear irq_req on the first cycle of an interrupt acknowledge (!M1_n & !IORQ_n), detected as a rising edge.
REQ-021 SHALL keep irq_req set, without queuing, when a tick arrives while it is already set; missed ticks are dropped.
REQ-022 SHALL keep irq_req set when a tick and an acknowledge coincide (set wins).
REQ-023 SHALL keep the counter running during and after an acknowledge; the acknowledge does not restart it.

Reset
REQ-024 SHALL, while reset = 1, force latch_dout = 8'h00, latch_pending = 0, irq_req = 0 (z80_irq_n = 1), dac1 = dac2 = 8'h80, counter = 0, and all edge-detect history registers = 0.
REQ-025 SHALL abandon any in-progress write or acknowledge when reset is asserted mid-operation; a strobe still active after reset releases counts as a new rising edge.

Structure
REQ-026 SHALL take IRQ_PERIOD default and DAC reset value 8'h80 from the shared terracresta_pkg package constants.
REQ-027 SHALL instantiate one sub-module, rise_pulse (1-bit registered rising-edge detector with synchronous reset), once per strobe: m68k write, z80 read, z80 clear, dac1, dac2, int-ack.

Verification
REQ-028 SHALL cover: M68K write of 8'h5A held 6 cycles -> latch_dout = 8'h5A and latch_pending = 1 after 1 cycle, exactly one load.
REQ-029 SHALL cover: Z80 latch read after REQ-028 -> latch_pending = 0, latch_dout still 8'h5A; clear port write -> latch_dout = 8'h00.
REQ-030 SHALL cover: M68K write of 8'h33 in the same cycle as a Z80 clear edge -> latch_dout = 8'h33, latch_pending = 1.
REQ-031 SHALL cover: IRQ_PERIOD = 8 -> z80_irq_n low at cycle 8 after reset; ack at cycle 10 -> high at cycle 11; low again at cycle 16.
REQ-032 SHALL cover: no ack for 3 periods -> z80_irq_n stays low; a single ack releases it until the next tick.
REQ-033 SHALL cover: reset pulse mid-write with dac1 = 8'h10 -> dac1 = 8'h80, latch_pending = 0, z80_irq_n = 1 on the cycle after reset.
